// File: rtl/ccg_stim_gen.sv
// Stimulus generator for the 29-input combinational benchmarks: emits a programmed
// number of LFSR, binary-count or walking-one vectors over a valid/ready stream.
module ccg_stim_gen #(
  parameter int          N_IN     = 29,
  parameter int          CNT_W    = 16,
  parameter logic [31:0] DEF_SEED = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             seed_load,
  input  logic [31:0]      seed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_IN-1:0]  x,
  output logic [CNT_W-1:0] vec_idx,
  output logic             busy,
  output logic             done
);

  localparam int WP_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic [1:0] MODE_COUNT = 2'd1;
  localparam logic [1:0] MODE_WALK1 = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [31:0]      s_reg, s_next;
  logic [31:0]      s_load;
  logic [1:0]       mode_reg, mode_next;
  logic [CNT_W-1:0] num_vec_reg, num_vec_next;
  logic [CNT_W-1:0] vec_idx_reg, vec_idx_next;
  logic [WP_W-1:0]  walk_pos_reg, walk_pos_next;
  logic [N_IN-1:0]  walk_vec;

  // Mode 3 is reserved and behaves as LFSR; WALK1 derives x from its own position counter.
  function automatic logic [31:0] step_state(input logic [1:0] m, input logic [31:0] s);
    case (m)
      MODE_COUNT: step_state = s + 32'd1;
      MODE_WALK1: step_state = s;
      default:    step_state = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      s_reg        <= DEF_SEED;
      mode_reg     <= 2'd0;
      num_vec_reg  <= '0;
      vec_idx_reg  <= '0;
      walk_pos_reg <= '0;
    end else begin
      state_reg    <= state_next;
      s_reg        <= s_next;
      mode_reg     <= mode_next;
      num_vec_reg  <= num_vec_next;
      vec_idx_reg  <= vec_idx_next;
      walk_pos_reg <= walk_pos_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    s_next        = s_reg;
    mode_next     = mode_reg;
    num_vec_next  = num_vec_reg;
    vec_idx_next  = vec_idx_reg;
    walk_pos_next = walk_pos_reg;
    s_load        = seed_load ? seed : s_reg;

    case (state_reg)
      IDLE: begin
        // abort outranks both seed_load and start, leaving s untouched
        if (!abort) begin
          s_next = s_load;
          if (start) begin
            mode_next     = mode;
            num_vec_next  = num_vec;
            vec_idx_next  = '0;
            walk_pos_next = '0;
            if (mode != MODE_COUNT && mode != MODE_WALK1 && s_load == 32'd0)
              s_next = 32'h1;
            state_next = (num_vec == '0) ? DONE : RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (out_ready) begin
          vec_idx_next  = vec_idx_reg + 1'b1;
          walk_pos_next = (walk_pos_reg == WP_W'(N_IN - 1)) ? '0 : walk_pos_reg + 1'b1;
          s_next        = step_state(mode_reg, s_reg);
          if (vec_idx_reg == num_vec_reg - 1'b1)
            state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_walk
      assign walk_vec[gi] = (walk_pos_reg == WP_W'(gi));
    end
  endgenerate

  assign out_valid = (state_reg == RUN);
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign vec_idx   = vec_idx_reg;
  assign x         = !out_valid ? '0 :
                     (mode_reg == MODE_WALK1) ? walk_vec : s_reg[N_IN-1:0];

endmodule

// File: tb/tb_ccg_stim_gen.sv
// Randomized self-checking bench for ccg_stim_gen against a sequence-level reference model.
module tb_ccg_stim_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] num_vec = '0;
  logic        seed_load = 1'b0;
  logic [31:0] seed = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [28:0] x;
  logic [15:0] vec_idx;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;

  logic [28:0] exp_x[$];
  logic [31:0] m_s;
  logic [28:0] got_x[$];
  int          got_idx[$];
  int          done_cnt, done_cyc, last_acc_cyc, stall_err;

  ccg_stim_gen #(.N_IN(29), .CNT_W(16), .DEF_SEED(32'h0000_0001)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .num_vec(num_vec), .seed_load(seed_load), .seed(seed), .out_valid(out_valid),
    .out_ready(out_ready), .x(x), .vec_idx(vec_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] fb;
    fb = ((s >> 31) ^ (s >> 21) ^ (s >> 1) ^ s) & 32'd1;
    return (s << 1) | fb;
  endfunction

  // Expected vector sequence of one run, plus the state left behind for the next run.
  task automatic model_run(input logic [1:0] m, input logic [31:0] s0, input int nv);
    logic [31:0] s;
    s = s0;
    exp_x.delete();
    if ((m == 2'd0 || m == 2'd3) && s == 32'd0) s = 32'd1;
    for (int i = 0; i < nv; i++) begin
      if (m == 2'd2) exp_x.push_back(29'(32'd1 << (i % 29)));
      else           exp_x.push_back(s[28:0]);
      if (m == 2'd1)      s = s + 32'd1;
      else if (m != 2'd2) s = lfsr_next(s);
    end
    m_s = s;
  endtask

  task automatic pulse_start(input logic [1:0] m, input int nv, input bit ld, input logic [31:0] sd);
    @(negedge clk);
    start = 1'b1; mode = m; num_vec = nv[15:0]; seed_load = ld; seed = sd;
    @(negedge clk);
    start = 1'b0; seed_load = 1'b0;
  endtask

  // Drives out_ready and records accepted vectors until the run returns to idle.
  task automatic collect(input int ready_pct, input int max_cyc);
    logic [28:0] px;
    logic [15:0] pidx;
    bit          pstall;
    bit          finished;
    got_x.delete(); got_idx.delete();
    done_cnt = 0; done_cyc = -1; last_acc_cyc = -1; stall_err = 0;
    pstall = 0; finished = 0; px = '0; pidx = '0;
    for (int c = 0; c < max_cyc; c++) begin
      if (pstall && (out_valid !== 1'b1 || x !== px || vec_idx !== pidx)) stall_err++;
      if (done === 1'b1) begin done_cnt++; done_cyc = c; end
      if (busy === 1'b0) begin finished = 1; break; end
      out_ready = ($urandom_range(99) < ready_pct);
      pstall = out_valid && !out_ready;
      px = x; pidx = vec_idx;
      if (out_valid && out_ready) begin
        got_x.push_back(x); got_idx.push_back(int'(vec_idx)); last_acc_cyc = c;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    total++;
    if (!finished) begin
      bad++;
      $display("FAIL collect_timeout: busy=%0b after %0d cycles, required idle", busy, max_cyc);
    end
  endtask

  task automatic test_reset();
    total += 5;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    if (x !== 29'd0) begin bad++; $display("FAIL reset_x: got %h want 0", x); end
    if (vec_idx !== 16'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", vec_idx); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
    $display("reset: valid=%0b x=%h idx=%0d busy=%0b done=%0b", out_valid, x, vec_idx, busy, done);
  endtask

  task automatic check_run(input string name, input int nv);
    total++;
    if (got_x.size() != nv) begin
      bad++; $display("FAIL %s_count: got %0d vectors want %0d", name, got_x.size(), nv);
    end
    for (int i = 0; i < got_x.size() && i < nv; i++) begin
      total += 2;
      if (got_x[i] !== exp_x[i]) begin
        bad++; $display("FAIL %s_x[%0d]: got %h want %h", name, i, got_x[i], exp_x[i]);
      end
      if (got_idx[i] != i) begin
        bad++; $display("FAIL %s_idx[%0d]: got %0d want %0d", name, i, got_idx[i], i);
      end
      $display("%s vec %0d: x=%h idx=%0d", name, i, got_x[i], got_idx[i]);
    end
    total += 3;
    if (done_cnt != 1) begin bad++; $display("FAIL %s_done_cnt: got %0d want 1", name, done_cnt); end
    if (done_cyc != last_acc_cyc + 1) begin
      bad++; $display("FAIL %s_done_time: got cycle %0d want %0d", name, done_cyc, last_acc_cyc + 1);
    end
    if (stall_err != 0) begin bad++; $display("FAIL %s_stall: %0d unstable stall cycles, want 0", name, stall_err); end
  endtask

  task automatic test_lfsr_basic();
    model_run(2'd0, 32'h1, 3);
    pulse_start(2'd0, 3, 1'b0, 32'h0);
    collect(100, 50);
    check_run("lfsr_basic", 3);
  endtask

  task automatic test_count_wrap();
    model_run(2'd1, 32'h1FFF_FFFE, 3);
    pulse_start(2'd1, 3, 1'b1, 32'h1FFF_FFFE);
    collect(100, 50);
    check_run("count_wrap", 3);
  endtask

  task automatic test_walk();
    model_run(2'd2, 32'h0, 31);
    pulse_start(2'd2, 31, 1'b0, 32'h0);
    collect(100, 100);
    check_run("walk", 31);
  endtask

  task automatic test_stall();
    logic [28:0] px;
    logic [15:0] pidx;
    int acc;
    model_run(2'd1, 32'h55, 6);
    pulse_start(2'd1, 6, 1'b1, 32'h55);
    acc = 0;
    for (int c = 0; c < 3; c++) begin
      out_ready = 1'b1;
      total++;
      if (x !== exp_x[acc] || vec_idx !== 16'(acc)) begin
        bad++; $display("FAIL stall_pre[%0d]: got x=%h idx=%0d want x=%h idx=%0d", acc, x, vec_idx, exp_x[acc], acc);
      end
      acc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    px = x; pidx = vec_idx;
    total++;
    if (px !== exp_x[3]) begin bad++; $display("FAIL stall_hold_vec: got %h want %h", px, exp_x[3]); end
    for (int c = 0; c < 5; c++) begin
      seed_load = 1'b1; seed = $urandom; start = 1'b1;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || x !== px || vec_idx !== pidx) begin
        bad++; $display("FAIL stall_cycle[%0d]: got v=%0b x=%h idx=%0d want v=1 x=%h idx=%0d", c, out_valid, x, vec_idx, px, pidx);
      end
      $display("stall cycle %0d: valid=%0b x=%h idx=%0d", c, out_valid, x, vec_idx);
    end
    seed_load = 1'b0; start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      out_ready = 1'b1;
      total++;
      if (x !== exp_x[acc] || vec_idx !== 16'(acc)) begin
        bad++; $display("FAIL stall_post[%0d]: got x=%h idx=%0d want x=%h idx=%0d", acc, x, vec_idx, exp_x[acc], acc);
      end
      acc++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    total += 2;
    if (done !== 1'b1) begin bad++; $display("FAIL stall_done: got %0b want 1", done); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_valid_end: got %0b want 0", out_valid); end
    @(negedge clk);
  endtask

  task automatic test_zero_vec();
    pulse_start(2'd0, 0, 1'b0, 32'h0);
    total += 2;
    if (done !== 1'b1) begin bad++; $display("FAIL zero_done: got %0b want 1", done); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL zero_valid: got %0b want 0", out_valid); end
    @(negedge clk);
    total += 2;
    if (done !== 1'b0) begin bad++; $display("FAIL zero_done_end: got %0b want 0", done); end
    if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_end: got %0b want 0", busy); end
    $display("zero_vec: done pulse observed, idle again busy=%0b", busy);
  endtask

  task automatic test_abort();
    logic [31:0] sd;
    sd = $urandom | 32'h1;
    model_run(2'd0, sd, 3);
    pulse_start(2'd0, 10, 1'b1, sd);
    for (int c = 0; c < 3; c++) begin
      out_ready = 1'b1;
      total++;
      if (x !== exp_x[c]) begin bad++; $display("FAIL abort_pre[%0d]: got %h want %h", c, x, exp_x[c]); end
      @(negedge clk);
    end
    out_ready = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_valid: got %0b want 0", out_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %0b want 0", busy); end
    for (int c = 0; c < 4; c++) begin
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL abort_done[%0d]: got %0b want 0", c, done); end
      @(negedge clk);
    end
    model_run(2'd0, m_s, 2);
    pulse_start(2'd0, 2, 1'b0, 32'h0);
    collect(100, 50);
    check_run("abort_resume", 2);
    // abort together with start in idle: nothing starts
    @(negedge clk);
    start = 1'b1; abort = 1'b1; num_vec = 16'd5;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_start_busy: got %0b want 0", busy); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_start_valid: got %0b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    pulse_start(2'd1, 20, 1'b1, 32'h100);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total += 4;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %0b want 0", out_valid); end
    if (x !== 29'd0) begin bad++; $display("FAIL arst_x: got %h want 0", x); end
    if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy: got %0b want 0", busy); end
    if (vec_idx !== 16'd0) begin bad++; $display("FAIL arst_idx: got %0d want 0", vec_idx); end
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_run(2'd0, 32'h1, 1);
    pulse_start(2'd0, 1, 1'b0, 32'h0);
    collect(100, 20);
    check_run("arst_resume", 1);
  endtask

  task automatic test_random();
    logic [1:0]  m;
    logic [31:0] sd;
    int          nv;
    for (int it = 0; it < 10; it++) begin
      m  = 2'($urandom_range(3));
      sd = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
      nv = $urandom_range(40, 1);
      model_run(m, sd, nv);
      pulse_start(m, nv, 1'b1, sd);
      collect(60, 2000);
      $display("random run %0d: mode=%0d seed=%h nv=%0d accepted=%0d", it, m, sd, nv, got_x.size());
      check_run("random", nv);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_lfsr_basic();
    test_count_wrap();
    test_walk();
    test_stall();
    test_zero_vec();
    test_abort();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
